// File: rtl/trade_order_gen.sv
// Order generator: turns accepted buy/sell strobes into single valid/ready orders,
// enforcing a signed position limit, a post-order cooldown and a saturating drop counter.
module trade_order_gen #(
    parameter logic [7:0] MAX_POS   = 8'd4,
    parameter logic [7:0] ORDER_QTY = 8'd1,
    parameter logic [7:0] COOLDOWN  = 8'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid_sma,
    input  logic       buy_signal,
    input  logic       sell_signal,
    input  logic [7:0] price,
    input  logic       order_ready,
    output logic       order_valid,
    output logic       order_side,
    output logic [7:0] order_price,
    output logic [7:0] order_qty,
    output logic [7:0] position,
    output logic       busy,
    output logic [7:0] drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_s;
    logic        order_valid_s;
    logic        order_side_s;
    logic [7:0]  order_price_s;
    logic [7:0]  order_qty_s;
    logic [7:0]  position_s;
    logic [7:0]  drop_count_s;

    logic        req_s;
    logic        buy_only_s;
    logic        sell_only_s;
    logic        buy_room_s;
    logic        sell_room_s;
    logic        accept_s;
    logic        drop_req_s;
    logic signed [8:0] pos_ext_s;
    logic signed [8:0] max_ext_s;
    logic signed [8:0] qty_ext_s;

    // Limit checks are done one bit wider so pos +/- qty can never wrap.
    assign pos_ext_s   = {position[7], position};
    assign max_ext_s   = {1'b0, MAX_POS};
    assign qty_ext_s   = {1'b0, ORDER_QTY};
    assign buy_room_s  = (pos_ext_s + qty_ext_s) <= max_ext_s;
    assign sell_room_s = (pos_ext_s - qty_ext_s) >= -max_ext_s;

    assign req_s       = data_valid_sma && (buy_signal || sell_signal);
    assign buy_only_s  = buy_signal && !sell_signal;
    assign sell_only_s = sell_signal && !buy_signal;
    assign accept_s    = (state_r == ST_IDLE) && req_s &&
                         ((buy_only_s && buy_room_s) || (sell_only_s && sell_room_s));
    assign drop_req_s  = req_s && !accept_s;

    // Next-state and next-output computation for the order FSM.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        order_valid_s = order_valid;
        order_side_s  = order_side;
        order_price_s = order_price;
        order_qty_s   = order_qty;
        position_s    = position;
        drop_count_s  = drop_count;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s       = ST_ISSUE;
                    order_valid_s = 1'b1;
                    order_side_s  = buy_only_s;
                    order_price_s = price;
                    order_qty_s   = ORDER_QTY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (order_valid && order_ready) begin
                    order_valid_s = 1'b0;
                    order_qty_s   = 8'd0;
                    if (order_side) begin
                        position_s = position + ORDER_QTY;
                    end else begin
                        position_s = position - ORDER_QTY;
                    end
                    if (COOLDOWN == 8'd0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_COOL;
                        cnt_s   = COOLDOWN - 8'd1;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_COOL: begin
                if (cnt_r == 8'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_s       = ST_IDLE;
                cnt_s         = 8'd0;
                order_valid_s = 1'b0;
                order_qty_s   = 8'd0;
            end
        endcase

        if (drop_req_s && (drop_count != 8'hFF)) begin
            drop_count_s = drop_count + 8'd1;
        end else begin
            drop_count_s = drop_count;
        end
    end

    // State and output registers; reset abandons any order in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            order_valid <= 1'b0;
            order_side  <= 1'b0;
            order_price <= 8'd0;
            order_qty   <= 8'd0;
            position    <= 8'd0;
            busy        <= 1'b0;
            drop_count  <= 8'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            order_valid <= order_valid_s;
            order_side  <= order_side_s;
            order_price <= order_price_s;
            order_qty   <= order_qty_s;
            position    <= position_s;
            busy        <= (state_s != ST_IDLE);
            drop_count  <= drop_count_s;
        end
    end

endmodule

// File: tb/tb_trade_order_gen.sv
// Self-checking bench for trade_order_gen: scoreboard of expected orders plus
// direct checks of position, busy and drop counter on default and zero-cooldown instances.
module tb_trade_order_gen;

    logic       clk;
    logic       rst;
    logic       data_valid_sma;
    logic       buy_signal;
    logic       sell_signal;
    logic [7:0] price;
    logic       order_ready;

    logic       order_valid, order_side, busy;
    logic [7:0] order_price, order_qty, position, drop_count;
    logic       o0_valid, o0_side, o0_busy;
    logic [7:0] o0_price, o0_qty, o0_position, o0_drop;

    typedef struct packed {
        logic       side;
        logic [7:0] price;
    } ord_t;

    ord_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    trade_order_gen dut (
        .clk(clk), .rst(rst), .data_valid_sma(data_valid_sma),
        .buy_signal(buy_signal), .sell_signal(sell_signal), .price(price),
        .order_ready(order_ready), .order_valid(order_valid), .order_side(order_side),
        .order_price(order_price), .order_qty(order_qty), .position(position),
        .busy(busy), .drop_count(drop_count)
    );

    trade_order_gen #(.COOLDOWN(8'd0)) dut0 (
        .clk(clk), .rst(rst), .data_valid_sma(data_valid_sma),
        .buy_signal(buy_signal), .sell_signal(sell_signal), .price(price),
        .order_ready(order_ready), .order_valid(o0_valid), .order_side(o0_side),
        .order_price(o0_price), .order_qty(o0_qty), .position(o0_position),
        .busy(o0_busy), .drop_count(o0_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic s, input logic [7:0] p);
        data_valid_sma = v;
        buy_signal     = b;
        sell_signal    = s;
        price          = p;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        check_val("idle_timeout", busy, 1'b0);
    endtask

    // Scoreboard: every handshake on the main instance must match the oldest expected order.
    always @(negedge clk) begin
        if (!rst && order_valid && order_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected", 32'd1, 32'd0);
            end else begin
                ord_t e;
                e = exp_q.pop_front();
                check_val("sb_side", order_side, e.side);
                check_val("sb_price", order_price, e.price);
                check_val("sb_qty", order_qty, 8'd1);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        order_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        #1;
        check_val("rst_valid", order_valid, 1'b0);
        check_val("rst_side", order_side, 1'b0);
        check_val("rst_price", order_price, 8'd0);
        check_val("rst_qty", order_qty, 8'd0);
        check_val("rst_pos", position, 8'd0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_drop", drop_count, 8'd0);
        tick();
        tick();
        rst = 1'b0;

        // Basic buy with ready already high
        order_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'd100);
        exp_q.push_back('{side: 1'b1, price: 8'd100});
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        check_val("t1_valid", order_valid, 1'b1);
        check_val("t1_side", order_side, 1'b1);
        check_val("t1_price", order_price, 8'd100);
        check_val("t1_qty", order_qty, 8'd1);
        check_val("t1_pos_at_accept", position, 8'd0);
        tick();
        check_val("t1_valid_after_hs", order_valid, 1'b0);
        check_val("t1_qty_after_hs", order_qty, 8'd0);
        check_val("t1_pos", position, 8'd1);
        for (int i = 0; i < 15; i++) tick();
        check_val("t1_busy_last", busy, 1'b1);
        tick();
        check_val("t1_busy_end", busy, 1'b0);

        // Stalled handshake with sells arriving during the stall
        order_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'd50);
        exp_q.push_back('{side: 1'b1, price: 8'd50});
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'd60 + 8'(i));
            tick();
            check_val("t2_hold_valid", order_valid, 1'b1);
            check_val("t2_hold_price", order_price, 8'd50);
            check_val("t2_hold_side", order_side, 1'b1);
            check_val("t2_hold_pos", position, 8'd1);
        end
        check_val("t2_drop5", drop_count, 8'd5);
        order_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'd70);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        check_val("t2_valid_after_hs", order_valid, 1'b0);
        check_val("t2_pos", position, 8'd2);
        check_val("t2_drop_hs_cycle", drop_count, 8'd6);
        wait_idle();

        // Position limit: four buys accepted, fifth dropped, then a sell
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'd10 + 8'(i));
            if (i < 4) exp_q.push_back('{side: 1'b1, price: 8'd10 + 8'(i)});
            tick();
            drive(1'b0, 1'b0, 1'b0, 8'd0);
            if (i < 4) begin
                check_val("t3_valid", order_valid, 1'b1);
                tick();
                check_val("t3_pos", position, 8'(i + 1));
                wait_idle();
            end else begin
                check_val("t3_limit_valid", order_valid, 1'b0);
                check_val("t3_limit_drop", drop_count, 8'd1);
                check_val("t3_limit_pos", position, 8'd4);
                check_val("t3_limit_busy", busy, 1'b0);
            end
        end
        drive(1'b1, 1'b0, 1'b1, 8'd77);
        exp_q.push_back('{side: 1'b0, price: 8'd77});
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        check_val("t3_sell_valid", order_valid, 1'b1);
        check_val("t3_sell_side", order_side, 1'b0);
        tick();
        check_val("t3_sell_pos", position, 8'd3);
        wait_idle();

        // Both signals high: dropped when valid, ignored when not valid
        drive(1'b1, 1'b1, 1'b1, 8'd5);
        tick();
        check_val("t4_both_valid", order_valid, 1'b0);
        check_val("t4_both_drop", drop_count, 8'd2);
        drive(1'b0, 1'b1, 1'b1, 8'd5);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'd5);
        tick();
        check_val("t4_novalid_drop", drop_count, 8'd2);
        check_val("t4_novalid_valid", order_valid, 1'b0);
        check_val("t4_novalid_busy", busy, 1'b0);

        // Cooldown window edge: request at H+16 dropped, at H+17 accepted
        drive(1'b1, 1'b0, 1'b1, 8'd20);
        exp_q.push_back('{side: 1'b0, price: 8'd20});
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        check_val("t5_pos_h", position, 8'd2);
        for (int i = 0; i < 15; i++) tick();
        drive(1'b1, 1'b0, 1'b1, 8'd21);
        tick();
        check_val("t5_h16_valid", order_valid, 1'b0);
        check_val("t5_h16_drop", drop_count, 8'd3);
        drive(1'b1, 1'b0, 1'b1, 8'd22);
        exp_q.push_back('{side: 1'b0, price: 8'd22});
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        check_val("t5_h17_valid", order_valid, 1'b1);
        check_val("t5_h17_price", order_price, 8'd22);
        tick();
        check_val("t5_pos_end", position, 8'd1);
        wait_idle();

        // Zero cooldown: back-to-back accept on the edge after the handshake
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 8'd33);
        exp_q.push_back('{side: 1'b1, price: 8'd33});
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        check_val("t6_c0_valid1", o0_valid, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'd34);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        check_val("t6_c0_valid2", o0_valid, 1'b1);
        check_val("t6_c0_price2", o0_price, 8'd34);
        check_val("t6_c0_pos1", o0_position, 8'd1);
        check_val("t6_c0_drop", o0_drop, 8'd0);
        check_val("t6_c16_drop", drop_count, 8'd1);
        tick();
        check_val("t6_c0_pos2", o0_position, 8'd2);
        check_val("t6_c16_pos", position, 8'd1);
        wait_idle();

        // Asynchronous reset while an order is stalled in ISSUE
        order_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'd90);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        check_val("t7_valid_pre", order_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t7_async_valid", order_valid, 1'b0);
        check_val("t7_async_pos", position, 8'd0);
        check_val("t7_async_drop", drop_count, 8'd0);
        check_val("t7_async_busy", busy, 1'b0);
        tick();
        rst = 1'b0;

        // Drop counter saturation
        drive(1'b1, 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 254; i++) tick();
        check_val("t8_drop254", drop_count, 8'd254);
        for (int i = 0; i < 46; i++) tick();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        check_val("t8_drop_sat", drop_count, 8'd255);
        check_val("t8_valid", order_valid, 1'b0);
        tick();
        check_val("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
